// File: rtl/uba_regrd_if.sv
// Backplane read-handshake signals between the bus initiator and the UBA read responder.
interface uba_regrd_if;
  logic        busREQI;
  logic [0:35] busADDRI;
  logic [0:35] busDATAO;
  logic        busACKO;

  modport slave  (input  busREQI, busADDRI, output busDATAO, busACKO);
  modport master (output busREQI, busADDRI, input  busDATAO, busACKO);
endinterface

// File: rtl/uba_regrd.sv
// UBA register read responder: decodes IO reads of the status, maintenance and paging
// registers and returns one acknowledged data word per request.
module uba_regrd #(
  parameter logic [3:0]  ubaNUM  = 4'd3,
  parameter logic [17:0] ubaSR   = 18'o763100,
  parameter logic [17:0] ubaMR   = 18'o763101,
  parameter logic [17:0] ubaPAGE = 18'o763000
) (
  input  logic        clk,
  input  logic        rst,
  uba_regrd_if.slave  bus,
  input  logic [0:35] regUBASR,
  input  logic [0:35] pageDATA,
  output logic [5:0]  pageADDR
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PGRD,
    ST_ACK,
    ST_DROP
  } state_t;

  state_t      state_q, state_d;
  logic        ack_q, ack_d;
  logic [0:35] dout_q, dout_d;
  logic [5:0]  page_addr_q, page_addr_d;

  logic [17:0] reg_addr;
  logic        io_rd;
  logic        sr_hit;
  logic        mr_hit;
  logic        page_hit;
  logic        unused_addr_bits;

  assign reg_addr = bus.busADDRI[18:35];
  assign io_rd    = bus.busREQI & bus.busADDRI[3] & bus.busADDRI[6] &
                    (bus.busADDRI[14:17] == ubaNUM);
  assign sr_hit   = io_rd && (reg_addr == ubaSR);
  assign mr_hit   = io_rd && (reg_addr == ubaMR);
  assign page_hit = io_rd && (reg_addr >= ubaPAGE) && (reg_addr <= ubaPAGE + 18'd63);

  assign unused_addr_bits = ^{bus.busADDRI[0:2], bus.busADDRI[4:5], bus.busADDRI[7:13]};

  always_comb begin
    state_d     = state_q;
    ack_d       = 1'b0;
    dout_d      = '0;
    page_addr_d = page_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (sr_hit) begin
          dout_d  = regUBASR;
          ack_d   = 1'b1;
          state_d = ST_ACK;
        end else if (mr_hit) begin
          // CR bit and everything else in the maintenance register read back as zero
          ack_d   = 1'b1;
          state_d = ST_ACK;
        end else if (page_hit) begin
          page_addr_d = bus.busADDRI[30:35];
          state_d     = ST_PGRD;
        end
      end
      ST_PGRD: begin
        dout_d  = pageDATA;
        ack_d   = 1'b1;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_DROP;
      end
      ST_DROP: begin
        // Hold off until the initiator releases the request so a held request acks once
        if (!bus.busREQI) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ack_q       <= 1'b0;
      dout_q      <= '0;
      page_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      dout_q      <= dout_d;
      page_addr_q <= page_addr_d;
    end
  end

  assign bus.busACKO  = ack_q;
  assign bus.busDATAO = dout_q;
  assign pageADDR     = page_addr_q;

endmodule
